// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - ARP receive parser: field check, reply request handshake, optional cache.
// Optional one-entry sender cache is built only when ARP_RX_CACHE_EN is defined.
module arp_rx #(
   parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] local_ip_addr,
   input  logic [7:0]  arp_rx_data,
   input  logic        arp_rx_valid,
   input  logic        arp_rx_end,
   input  logic        arp_reply_ack,
   output logic        arp_reply_req,
   output logic [31:0] arp_rec_source_ip_addr,
   output logic [47:0] arp_rec_source_mac_addr,
   output logic        arp_found,
   output logic        arp_rx_err,
   output logic [47:0] cache_mac_addr,
   output logic        cache_valid
);

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      CHECK,
      REPLY_WAIT,
      DISCARD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  byte_cnt;
   logic [4:0]  byte_idx;
   logic [15:0] to_cnt;
   logic [15:0] to_nxt;
   logic [15:0] htype;
   logic [15:0] ptype;
   logic [7:0]  hlen;
   logic [7:0]  plen;
   logic [15:0] opcode;
   logic [47:0] sha;
   logic [31:0] spa;
   logic [31:0] tpa;
   logic        capture;
   logic        accept;

   // A byte in IDLE is always byte 0 of a new frame, so the index is forced to zero there.
   assign capture  = arp_rx_valid && ((state == IDLE) || (state == RECV));
   assign byte_idx = (state == IDLE) ? 5'd0 : byte_cnt;
   assign to_nxt   = to_cnt + 16'd1;

   assign accept = (htype == 16'h0001) && (ptype == 16'h0800) &&
                   (hlen == 8'h06) && (plen == 8'h04) &&
                   ((opcode == 16'h0001) || (opcode == 16'h0002)) &&
                   (tpa == local_ip_addr);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (arp_rx_valid) begin
               state_nxt = arp_rx_end ? DISCARD : RECV;
            end
         end
         RECV: begin
            // End beat at index 27 or later means at least 28 bytes arrived.
            if (arp_rx_valid && arp_rx_end) begin
               state_nxt = (byte_cnt >= 5'd27) ? CHECK : DISCARD;
            end
         end
         CHECK: begin
            if (!accept) begin
               state_nxt = DISCARD;
            end else if (opcode == 16'h0001) begin
               state_nxt = REPLY_WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         REPLY_WAIT: begin
            if (arp_reply_ack || (to_nxt == ACK_TIMEOUT)) begin
               state_nxt = IDLE;
            end
         end
         DISCARD: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         byte_cnt                <= 5'd0;
         to_cnt                  <= 16'd0;
         arp_reply_req           <= 1'b0;
         arp_found               <= 1'b0;
         arp_rx_err              <= 1'b0;
         arp_rec_source_ip_addr  <= 32'd0;
         arp_rec_source_mac_addr <= 48'd0;
      end else begin
         state         <= state_nxt;
         arp_reply_req <= (state_nxt == REPLY_WAIT);
         arp_found     <= (state == CHECK) && accept && (opcode == 16'h0002);
         arp_rx_err    <= (state_nxt == DISCARD);

         if (capture) begin
            if (arp_rx_end) begin
               byte_cnt <= 5'd0;
            end else if (byte_idx < 5'd28) begin
               byte_cnt <= byte_idx + 5'd1;
            end
         end else if (state != RECV) begin
            byte_cnt <= 5'd0;
         end

         if (state == REPLY_WAIT) begin
            to_cnt <= to_nxt;
         end else begin
            to_cnt <= 16'd0;
         end

         if ((state == CHECK) && accept) begin
            arp_rec_source_ip_addr  <= spa;
            arp_rec_source_mac_addr <= sha;
         end
      end
   end

   // Field capture; target hardware address and padding bytes are not stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         htype  <= 16'd0;
         ptype  <= 16'd0;
         hlen   <= 8'd0;
         plen   <= 8'd0;
         opcode <= 16'd0;
         sha    <= 48'd0;
         spa    <= 32'd0;
         tpa    <= 32'd0;
      end else if (capture) begin
         case (byte_idx)
            5'd0:    htype[15:8]  <= arp_rx_data;
            5'd1:    htype[7:0]   <= arp_rx_data;
            5'd2:    ptype[15:8]  <= arp_rx_data;
            5'd3:    ptype[7:0]   <= arp_rx_data;
            5'd4:    hlen         <= arp_rx_data;
            5'd5:    plen         <= arp_rx_data;
            5'd6:    opcode[15:8] <= arp_rx_data;
            5'd7:    opcode[7:0]  <= arp_rx_data;
            5'd8:    sha[47:40]   <= arp_rx_data;
            5'd9:    sha[39:32]   <= arp_rx_data;
            5'd10:   sha[31:24]   <= arp_rx_data;
            5'd11:   sha[23:16]   <= arp_rx_data;
            5'd12:   sha[15:8]    <= arp_rx_data;
            5'd13:   sha[7:0]     <= arp_rx_data;
            5'd14:   spa[31:24]   <= arp_rx_data;
            5'd15:   spa[23:16]   <= arp_rx_data;
            5'd16:   spa[15:8]    <= arp_rx_data;
            5'd17:   spa[7:0]     <= arp_rx_data;
            5'd24:   tpa[31:24]   <= arp_rx_data;
            5'd25:   tpa[23:16]   <= arp_rx_data;
            5'd26:   tpa[15:8]    <= arp_rx_data;
            5'd27:   tpa[7:0]     <= arp_rx_data;
            default: ;
         endcase
      end
   end

`ifdef ARP_RX_CACHE_EN
   logic [31:0] cache_ip;
   logic [47:0] cache_mac;
   logic        cache_ent;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_ip  <= 32'd0;
         cache_mac <= 48'd0;
         cache_ent <= 1'b0;
      end else if ((state == CHECK) && accept) begin
         cache_ip  <= spa;
         cache_mac <= sha;
         cache_ent <= 1'b1;
      end
   end

   // The lookup address is the last accepted sender IP.
   assign cache_valid    = cache_ent && (cache_ip == arp_rec_source_ip_addr);
   assign cache_mac_addr = cache_mac;
`else
   assign cache_valid    = 1'b0;
   assign cache_mac_addr = 48'd0;
`endif

endmodule

// File: tb/tb_arp_rx.sv
// tb/tb_arp_rx.sv - scoreboard bench for arp_rx with randomized frames and a frame-level model.
module tb_arp_rx;

   localparam int          TO  = 16;
   localparam logic [31:0] LIP = 32'hC0A80002;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] local_ip_addr;
   logic [7:0]  arp_rx_data;
   logic        arp_rx_valid;
   logic        arp_rx_end;
   logic        arp_reply_ack;
   logic        arp_reply_req;
   logic [31:0] arp_rec_source_ip_addr;
   logic [47:0] arp_rec_source_mac_addr;
   logic        arp_found;
   logic        arp_rx_err;
   logic [47:0] cache_mac_addr;
   logic        cache_valid;

   arp_rx #(.ACK_TIMEOUT(16'd16)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .local_ip_addr           (local_ip_addr),
      .arp_rx_data             (arp_rx_data),
      .arp_rx_valid            (arp_rx_valid),
      .arp_rx_end              (arp_rx_end),
      .arp_reply_ack           (arp_reply_ack),
      .arp_reply_req           (arp_reply_req),
      .arp_rec_source_ip_addr  (arp_rec_source_ip_addr),
      .arp_rec_source_mac_addr (arp_rec_source_mac_addr),
      .arp_found               (arp_found),
      .arp_rx_err              (arp_rx_err),
      .cache_mac_addr          (cache_mac_addr),
      .cache_valid             (cache_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 reply request, 1 found, 2 error
      int          cyc;    // end-beat cycle, -1 when timing is not checked
      logic [31:0] ip;
      logic [47:0] mac;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        req_q = 1'b0;
   logic [7:0]  fb[0:63];
   int          flen;
   int          g_kind;
   logic [31:0] g_ip;
   logic [47:0] g_mac;
   logic [31:0] m_ip = 32'd0;
   logic [47:0] m_mac = 48'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         req_q = 1'b0;
      end else begin
         if (arp_found || arp_rx_err || (arp_reply_req && !req_q)) begin
            int   k;
            exp_t e;
            k = (arp_reply_req && !req_q) ? 0 : (arp_found ? 1 : 2);
            chk("excl", 64'(arp_found && arp_rx_err), 64'd0);
            if (expq.size() == 0) begin
               chk("unexpected_event", 64'(k), 64'hFF);
            end else begin
               e = expq.pop_front();
               chk("event_kind", 64'(k), 64'(e.kind));
               if (e.cyc >= 0) begin
                  if (k == 2) chk("err_timing", 64'((cyc - e.cyc >= 1) && (cyc - e.cyc <= 3)), 64'd1);
                  else        chk("out_timing", 64'(cyc - e.cyc), 64'd2);
               end
               if (k != 2) begin
                  chk("rec_ip", 64'(arp_rec_source_ip_addr), 64'(e.ip));
                  chk("rec_mac", 64'(arp_rec_source_mac_addr), 64'(e.mac));
               end
            end
         end
         req_q = arp_reply_req;
      end
   end

   // Frame model: accept iff all fixed fields match, the target is ours and the frame is long enough.
   task automatic build(input logic [15:0] ht, input logic [15:0] pt, input logic [7:0] hl,
                        input logic [7:0] pl, input logic [15:0] op, input logic [47:0] sha,
                        input logic [31:0] spa, input logic [31:0] tpa, input int len);
      logic [223:0] v;
      logic [47:0]  tha;
      tha = {16'($urandom), 32'($urandom)};
      v   = {ht, pt, hl, pl, op, sha, spa, tha, tpa};
      for (int i = 0; i < len; i++) fb[i] = (i < 28) ? v[223 - 8*i -: 8] : 8'($urandom);
      flen = len;
      if (len >= 28 && ht == 16'h0001 && pt == 16'h0800 && hl == 8'h06 && pl == 8'h04 &&
          tpa == LIP && (op == 16'h0001 || op == 16'h0002)) begin
         g_kind = (op == 16'h0001) ? 0 : 1;
         g_ip   = spa;
         g_mac  = sha;
      end else begin
         g_kind = 2;
      end
   endtask

   task automatic send(input bit timed);
      exp_t e;
      for (int i = 0; i < flen; i++) begin
         @(posedge clk); #1;
         arp_rx_valid = 1'b1;
         arp_rx_data  = fb[i];
         arp_rx_end   = (i == flen - 1);
         if (i == flen - 1) begin
            e.kind = g_kind;
            e.cyc  = timed ? cyc : -1;
            e.ip   = g_ip;
            e.mac  = g_mac;
            expq.push_back(e);
            if (g_kind < 2) begin
               m_ip  = g_ip;
               m_mac = g_mac;
            end
         end
      end
      @(posedge clk); #1;
      arp_rx_valid = 1'b0;
      arp_rx_end   = 1'b0;
   endtask

   task automatic measure_timeout();
      int n = 0;
      while (arp_reply_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_len", 64'(n), 64'(TO));
   endtask

   task automatic wait_req();
      int n = 0;
      while (!arp_reply_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_rise", 64'(arp_reply_req), 64'd1);
   endtask

   task automatic settle();
      int n = 0;
      while (expq.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(expq.size()), 64'd0);
      expq.delete();
      @(negedge clk);
      chk("rec_ip_hold", 64'(arp_rec_source_ip_addr), 64'(m_ip));
      chk("rec_mac_hold", 64'(arp_rec_source_mac_addr), 64'(m_mac));
      chk("cache_valid", 64'(cache_valid), 64'd0);
      chk("cache_mac", 64'(cache_mac_addr), 64'd0);
      repeat (2) @(posedge clk);
   endtask

   // ack_delay < 0 lets the request time out.
   task automatic do_frame(input int ack_delay);
      int k;
      k = g_kind;
      send(1'b1);
      if (k == 0) begin
         wait_req();
         if (ack_delay >= 0) begin
            repeat (ack_delay) @(posedge clk);
            #1;
            chk("req_hold", 64'(arp_reply_req), 64'd1);
            arp_reply_ack = 1'b1;
            @(posedge clk); #1;
            arp_reply_ack = 1'b0;
            @(negedge clk);
            chk("ack_drop", 64'(arp_reply_req), 64'd0);
         end else begin
            measure_timeout();
         end
      end
      settle();
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_req"}, 64'(arp_reply_req), 64'd0);
      chk({nm, "_found"}, 64'(arp_found), 64'd0);
      chk({nm, "_err"}, 64'(arp_rx_err), 64'd0);
      chk({nm, "_ip"}, 64'(arp_rec_source_ip_addr), 64'd0);
      chk({nm, "_mac"}, 64'(arp_rec_source_mac_addr), 64'd0);
      chk({nm, "_cache"}, 64'({cache_valid, cache_mac_addr}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [15:0] op;
      rst_n         = 1'b0;
      local_ip_addr = LIP;
      arp_rx_data   = 8'd0;
      arp_rx_valid  = 1'b0;
      arp_rx_end    = 1'b0;
      arp_reply_ack = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h001122334455, 32'hC0A80003, LIP, 28);
      do_frame(5);
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h001122334455, 32'hC0A80003, LIP, 46);
      do_frame(5);
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, 48'hA0B0C0D0E0F0, 32'hC0A80077, LIP, 28);
      do_frame(0);
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h665544332211, 32'hC0A80005, 32'hC0A80009, 28);
      do_frame(0);
      build(16'h0001, 16'h86DD, 8'h06, 8'h04, 16'h0001, 48'h665544332211, 32'hC0A80005, LIP, 28);
      do_frame(0);
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h665544332211, 32'hC0A80005, LIP, 21);
      do_frame(0);

      // Ack outside REPLY_WAIT must produce no event.
      @(posedge clk); #1;
      arp_reply_ack = 1'b1;
      @(posedge clk); #1;
      arp_reply_ack = 1'b0;
      settle();

      // Timeout, with a second frame arriving during REPLY_WAIT; its tail becomes a short frame.
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80010, LIP, 28);
      send(1'b1);
      wait_req();
      fork
         measure_timeout();
         begin
            repeat (2) @(posedge clk);
            build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'hDEADBEEF0001, 32'hC0A80020, LIP, 28);
            g_kind = 2;
            send(1'b0);
         end
      join
      settle();

      // Reset in the middle of a request.
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h112233445566, 32'hC0A80030, LIP, 28);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         arp_rx_valid = 1'b1;
         arp_rx_data  = fb[i];
      end
      #2;
      rst_n        = 1'b0;
      arp_rx_valid = 1'b0;
      #1;
      check_zero("midreset");
      m_ip  = 32'd0;
      m_mac = 48'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      build(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h112233445566, 32'hC0A80030, LIP, 28);
      do_frame(2);

      for (int f = 0; f < 40; f++) begin
         r  = $urandom_range(0, 9);
         op = (r == 2) ? 16'h0002 : 16'h0001;
         if (r == 8) op = 16'($urandom_range(3, 16'hFFFF));
         build((r == 4) ? 16'($urandom_range(2, 9)) : 16'h0001,
               (r == 5) ? 16'h86DD : 16'h0800,
               (r == 6) ? 8'h08 : 8'h06,
               (r == 7) ? 8'h10 : 8'h04,
               op,
               {16'($urandom), 32'($urandom)},
               32'($urandom),
               (r == 3) ? 32'($urandom) : LIP,
               (r == 9) ? $urandom_range(1, 27) : $urandom_range(28, 46));
         do_frame(($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 10));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
